muldiv_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide resource in the EX stage. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX `alucontrol` code and latches the forwarded operands. It starts the fixed-latency multiplier or divider IP, counts its latency and stalls the pipeline while the op is in flight. It owns the HI/LO register pair and provides the MFHI/MFLO read value to the EX result mux.

---
 rtl/muldiv_ctrl_pkg.sv | 41 ++++
 rtl/muldiv_ctrl_hilo_regs.sv | 51 +++++
 rtl/muldiv_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// defines
// Shared constants for the EX-stage multiply/divide controller:
//   - EXE_*_OP  : 8-bit alucontrol codes decoded by muldiv_ctrl
//   - state_e   : controller FSM state encoding
//   - helpers   : op-class decode functions
// -----------------------------------------------------------------------------
package defines;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Ops that occupy the shared multiply/divide unit.
  function automatic logic is_muldiv_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// -----------------------------------------------------------------------------
// hilo_regs
// HI/LO architectural register pair with independent write enables and a
// combinational read mux for MFHI/MFLO.
// Ports:
//   clk, rst              clock / synchronous active-low reset
//   hi_we_i, hi_wdata_i   HI write enable / data
//   lo_we_i, lo_wdata_i   LO write enable / data
//   rd_hi_i, rd_lo_i      select HI or LO onto rdata_o (0 when neither)
//   rdata_o               read value
// -----------------------------------------------------------------------------
module hilo_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we_i,
  input  logic [31:0] hi_wdata_i,
  input  logic        lo_we_i,
  input  logic [31:0] lo_wdata_i,
  input  logic        rd_hi_i,
  input  logic        rd_lo_i,
  output logic [31:0] rdata_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_we_i ? hi_wdata_i : hi_q;
    lo_d = lo_we_i ? lo_wdata_i : lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rd_hi_i) begin
      rdata_o = hi_q;
    end else if (rd_lo_i) begin
      rdata_o = lo_q;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// EX-stage sequencer for the shared fixed-latency multiplier/divider.
// Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO, latches operands, pulses
// the IP start, counts its latency while stalling the pipeline, and writes
// the result into the HI/LO pair.
// Ports:
//   clk, rst                  clock / synchronous active-low reset
//   op_valid, alucontrol      EX instruction valid / op code
//   src_a, src_b              forwarded rs / rt operands
//   flush                     cancel EX instruction and any in-flight op
//   mul_start, div_start      one-cycle start pulses to the IP
//   unit_a, unit_b, unit_signed  operands held stable for the IP
//   mul_result, div_result    IP results (div = {remainder, quotient})
//   stall                     hold IF/ID/EX
//   hilo_rdata                MFHI/MFLO read value, else 0
//   div_by_zero               pulse when a divide had divisor 0
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import defines::*;
#(
  parameter int MUL_LAT = 6,
  parameter int DIV_LAT = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        mul_start,
  output logic        div_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_signed,
  input  logic [63:0] mul_result,
  input  logic [63:0] div_result,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic        div_by_zero
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      unit_a_q, unit_a_d;
  logic [31:0]      unit_b_q, unit_b_d;
  logic             unit_signed_q, unit_signed_d;
  logic             is_div_q, is_div_d;   // op in flight is a divide
  logic             div0_q, div0_d;       // divide skipped: divisor was 0

  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        rd_hi, rd_lo;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    unit_signed_d = unit_signed_q;
    is_div_d      = is_div_q;
    div0_d        = div0_q;
    stall         = 1'b0;
    mul_start     = 1'b0;
    div_start     = 1'b0;
    div_by_zero   = 1'b0;
    hi_we         = 1'b0;
    lo_we         = 1'b0;
    hi_wdata      = '0;
    lo_wdata      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          if (is_muldiv_op(alucontrol)) begin
            stall         = 1'b1;
            unit_a_d      = src_a;
            unit_b_d      = src_b;
            unit_signed_d = is_signed_op(alucontrol);
            is_div_d      = is_div_op(alucontrol);
            div0_d        = 1'b0;
            cnt_d         = '0;
            if (!is_div_op(alucontrol)) begin
              state_d = ST_MUL_BUSY;
            end else if (src_b == '0) begin
              // Never start the divider on a zero divisor; just report it.
              state_d = ST_DONE;
              div0_d  = 1'b1;
            end else begin
              state_d = ST_DIV_BUSY;
            end
          end else if (alucontrol == EXE_MTHI_OP) begin
            hi_we    = 1'b1;
            hi_wdata = src_a;
          end else if (alucontrol == EXE_MTLO_OP) begin
            lo_we    = 1'b1;
            lo_wdata = src_a;
          end
        end
      end

      ST_MUL_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall     = 1'b1;
          // Counter is only zero in the first busy cycle.
          mul_start = (cnt_q == '0);
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == MUL_LAST) state_d = ST_DONE;
        end
      end

      ST_DIV_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall     = 1'b1;
          div_start = (cnt_q == '0);
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == DIV_LAST) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Return to IDLE unconditionally: the op code still shows the
        // finished instruction here and must not re-issue.
        state_d = ST_IDLE;
        if (!flush) begin
          if (div0_q) begin
            div_by_zero = 1'b1;
          end else if (is_div_q) begin
            hi_we    = 1'b1;
            hi_wdata = div_result[63:32];
            lo_we    = 1'b1;
            lo_wdata = div_result[31:0];
          end else begin
            hi_we    = 1'b1;
            hi_wdata = mul_result[63:32];
            lo_we    = 1'b1;
            lo_wdata = mul_result[31:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Hold every control output quiet while reset is applied.
    if (!rst) begin
      stall       = 1'b0;
      mul_start   = 1'b0;
      div_start   = 1'b0;
      div_by_zero = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_signed_q <= 1'b0;
      is_div_q      <= 1'b0;
      div0_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      unit_signed_q <= unit_signed_d;
      is_div_q      <= is_div_d;
      div0_q        <= div0_d;
    end
  end

  assign unit_a      = unit_a_q;
  assign unit_b      = unit_b_q;
  assign unit_signed = unit_signed_q;

  assign rd_hi = op_valid && (alucontrol == EXE_MFHI_OP);
  assign rd_lo = op_valid && (alucontrol == EXE_MFLO_OP);

  hilo_regs u_hilo_regs (
    .clk        (clk),
    .rst        (rst),
    .hi_we_i    (hi_we),
    .hi_wdata_i (hi_wdata),
    .lo_we_i    (lo_we),
    .lo_wdata_i (lo_wdata),
    .rd_hi_i    (rd_hi),
    .rd_lo_i    (rd_lo),
    .rdata_o    (hilo_rdata)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import defines::*;

  localparam int MUL_LAT = 6;
  localparam int DIV_LAT = 36;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [7:0]  alucontrol;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        mul_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        unit_signed;
  logic [63:0] mul_result, div_result;
  logic        stall;
  logic [31:0] hilo_rdata;
  logic        div_by_zero;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .alucontrol  (alucontrol),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .mul_start   (mul_start),
    .div_start   (div_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_signed (unit_signed),
    .mul_result  (mul_result),
    .div_result  (div_result),
    .stall       (stall),
    .hilo_rdata  (hilo_rdata),
    .div_by_zero (div_by_zero)
  );

  // Fixed-latency IP stand-ins: result is valid only in the single cycle
  // it is due, and junk otherwise, so early or late captures show up.
  logic        mul_armed = 1'b0, div_armed = 1'b0;
  int          mul_rem = 0, div_rem = 0;
  logic [63:0] mul_val = '0, div_val = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      mul_armed <= 1'b1;
      mul_rem   <= MUL_LAT - 1;
      if (unit_signed) mul_val <= $signed(unit_a) * $signed(unit_b);
      else             mul_val <= {32'd0, unit_a} * {32'd0, unit_b};
    end else if (mul_armed) begin
      if (mul_rem == 0) mul_armed <= 1'b0;
      else              mul_rem   <= mul_rem - 1;
    end
    if (div_start) begin
      div_armed <= 1'b1;
      div_rem   <= DIV_LAT - 1;
      if (unit_signed)
        div_val <= {32'($signed(unit_a) % $signed(unit_b)), 32'($signed(unit_a) / $signed(unit_b))};
      else
        div_val <= {unit_a % unit_b, unit_a / unit_b};
    end else if (div_armed) begin
      if (div_rem == 0) div_armed <= 1'b0;
      else              div_rem   <= div_rem - 1;
    end
  end

  assign mul_result = (mul_armed && mul_rem == 0) ? mul_val : JUNK;
  assign div_result = (div_armed && div_rem == 0) ? div_val : JUNK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a mul/div op and hold it (as a stalled EX stage would) until the
  // first non-stall cycle (DONE), tallying stall cycles and pulses.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input int exp_ms, input int exp_ds,
                        input int exp_dbz, input logic exp_sgn);
    int   ns, nms, nds, ndbz;
    logic sgn_seen, done;
    ns = 0; nms = 0; nds = 0; ndbz = 0; sgn_seen = 1'b0; done = 1'b0;
    op_valid = 1'b1; alucontrol = op; src_a = a; src_b = b;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (mul_start || div_start) begin
        sgn_seen = unit_signed;
        check({tag, "_unit_a"}, {32'd0, unit_a}, {32'd0, a});
        check({tag, "_unit_b"}, {32'd0, unit_b}, {32'd0, b});
      end
      if (mul_start)   nms++;
      if (div_start)   nds++;
      if (div_by_zero) ndbz++;
      if (stall) ns++;
      else       done = 1'b1;
      tick();
    end
    op_valid = 1'b0; alucontrol = EXE_NOP_OP; src_a = '0; src_b = '0;
    check({tag, "_done"},     {63'd0, done}, 64'd1);
    check({tag, "_stall"},    64'(ns),   64'(exp_stall));
    check({tag, "_mulstart"}, 64'(nms),  64'(exp_ms));
    check({tag, "_divstart"}, 64'(nds),  64'(exp_ds));
    check({tag, "_dbz"},      64'(ndbz), 64'(exp_dbz));
    if (exp_ms + exp_ds > 0) check({tag, "_signed"}, {63'd0, sgn_seen}, {63'd0, exp_sgn});
  endtask

  task automatic read_hilo(input string tag, input logic [7:0] op, input logic [31:0] exp);
    op_valid = 1'b1; alucontrol = op;
    @(negedge clk);
    check(tag, {32'd0, hilo_rdata}, {32'd0, exp});
    check({tag, "_nostall"}, {63'd0, stall}, 64'd0);
    tick();
    op_valid = 1'b0; alucontrol = EXE_NOP_OP;
  endtask

  task automatic move_to(input logic [7:0] op, input logic [31:0] a);
    op_valid = 1'b1; alucontrol = op; src_a = a;
    @(negedge clk);
    check("mt_nostall", {63'd0, stall}, 64'd0);
    tick();
    op_valid = 1'b0; alucontrol = EXE_NOP_OP; src_a = '0;
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; alucontrol = EXE_NOP_OP;
    src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // Reset state
    op_valid = 1'b1; alucontrol = EXE_MFHI_OP;
    @(negedge clk);
    check("rst_mfhi",  {32'd0, hilo_rdata}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_start", {62'd0, mul_start, div_start}, 64'd0);
    tick();
    op_valid = 1'b0;
    read_hilo("rst_mflo", EXE_MFLO_OP, 32'd0);

    // MULT -2 * 3 = 0xFFFFFFFF_FFFFFFFA
    run_op("mult", EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, MUL_LAT + 1, 1, 0, 0, 1'b1);
    read_hilo("mult_hi", EXE_MFHI_OP, 32'hFFFF_FFFF);
    read_hilo("mult_lo", EXE_MFLO_OP, 32'hFFFF_FFFA);

    // MTHI then read back
    move_to(EXE_MTHI_OP, 32'h0000_CAFE);
    read_hilo("mthi_hi", EXE_MFHI_OP, 32'h0000_CAFE);

    // DIVU 100 / 7 -> q=14, r=2
    run_op("divu", EXE_DIVU_OP, 32'd100, 32'd7, DIV_LAT + 1, 0, 1, 0, 1'b0);
    read_hilo("divu_lo", EXE_MFLO_OP, 32'd14);
    read_hilo("divu_hi", EXE_MFHI_OP, 32'd2);

    // DIV by zero: one stall cycle, no start, HI/LO untouched
    run_op("div0", EXE_DIV_OP, 32'd55, 32'd0, 1, 0, 0, 1, 1'b1);
    read_hilo("div0_hi", EXE_MFHI_OP, 32'd2);
    read_hilo("div0_lo", EXE_MFLO_OP, 32'd14);

    // Flush MULT 5*5 while counter==3
    op_valid = 1'b1; alucontrol = EXE_MULT_OP; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    check("fl_issue_stall", {63'd0, stall}, 64'd1);
    tick();                    // first busy cycle, counter 0
    repeat (3) tick();         // now counter 3
    flush = 1'b1;
    @(negedge clk);
    check("fl_stall", {63'd0, stall}, 64'd0);
    tick();
    flush = 1'b0;
    // Back in IDLE straight away, so MTLO must take effect now
    move_to(EXE_MTLO_OP, 32'h0000_1234);
    repeat (8) tick();         // let the abandoned result go by
    read_hilo("fl_lo", EXE_MFLO_OP, 32'h0000_1234);
    read_hilo("fl_hi", EXE_MFHI_OP, 32'd2);

    // Reset during DIV_BUSY
    op_valid = 1'b1; alucontrol = EXE_DIVU_OP; src_a = 32'd100; src_b = 32'd7;
    repeat (10) tick();
    @(negedge clk);
    check("rd_busy_stall", {63'd0, stall}, 64'd1);
    tick();
    rst = 1'b0; op_valid = 1'b0; alucontrol = EXE_NOP_OP;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rd_stall", {63'd0, stall}, 64'd0);
    tick();
    read_hilo("rd_hi", EXE_MFHI_OP, 32'd0);
    read_hilo("rd_lo", EXE_MFLO_OP, 32'd0);

    // MULTU 2 * 3 after reset
    run_op("multu", EXE_MULTU_OP, 32'd2, 32'd3, MUL_LAT + 1, 1, 0, 0, 1'b0);
    read_hilo("multu_lo", EXE_MFLO_OP, 32'd6);
    read_hilo("multu_hi", EXE_MFHI_OP, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
